// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. CPU stores to TX_ADDR enqueue bytes
// into a small circular FIFO; a four-state serializer drains it onto txd.
// Status {overflow, fifo_full, busy} is read combinationally at STAT_ADDR.
module uart_tx_mmio #(
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  TX_ADDR    = 8'hF0,
  parameter logic [7:0]  STAT_ADDR  = 8'hF1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_tick,
  input  logic [7:0] address,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       txd,
  output logic       busy,
  output logic       fifo_full
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               push_req;
  logic               clr_req;
  logic               push_ok;
  logic               pop;
  logic               baud_end;

  // A CPU store lasts many clk cycles; cpu_tick qualifies it to a single event.
  assign push_req  = cpu_tick && we && (address == TX_ADDR);
  assign clr_req   = cpu_tick && we && (address == STAT_ADDR);
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_ok   = push_req && !fifo_full;
  assign baud_end  = (baud_q == BAUD_W'(DIV - 1));
  assign busy      = (state_q != S_IDLE) || (count_q != '0);
  assign rdata     = (address == STAT_ADDR) ? {5'b0, ovf_q, fifo_full, busy} : 8'h00;

  // Serializer state register; reset lands in IDLE so txd goes high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Serializer next-state, pop request and line level.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd     = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        txd = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a push seen while full is dropped even if a pop coincides.
  always_comb begin
    wptr_d  = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    ovf_d = ovf_q;
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end
    if (clr_req) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents become don't-care once reset zeroes the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule
